// File: rtl/chess_display_pkg.sv
// Shared geometry, region encodings and FSM state for the chess display path.
// Pure declarations; no timing of its own.
// Not applicable: holds no handshake.
package chess_display_pkg;

  localparam int LCD_WIDTH     = 240;
  localparam int LCD_HEIGHT    = 320;
  localparam int BANNER_HEIGHT = 40;
  localparam int SQUARE_SIZE   = 30;

  typedef logic [7:0] xaddr_t;
  typedef logic [8:0] yaddr_t;

  // Derived rectangle corners used by the scheduler
  localparam xaddr_t X_MAX        = xaddr_t'(LCD_WIDTH - 1);
  localparam yaddr_t Y_MAX        = yaddr_t'(LCD_HEIGHT - 1);
  localparam yaddr_t TOP_Y_END    = yaddr_t'(BANNER_HEIGHT - 1);
  localparam yaddr_t BOTTOM_Y0    = yaddr_t'(LCD_HEIGHT - BANNER_HEIGHT);
  localparam yaddr_t BOARD_Y0     = yaddr_t'(BANNER_HEIGHT);
  localparam xaddr_t SQ_SPAN_X    = xaddr_t'(SQUARE_SIZE - 1);
  localparam yaddr_t SQ_SPAN_Y    = yaddr_t'(SQUARE_SIZE - 1);

  typedef enum logic [1:0] {
    REGION_FRAME  = 2'd0,
    REGION_BANNER = 2'd1,
    REGION_SQUARE = 2'd2
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    xaddr_t x0;
    yaddr_t y0;
    xaddr_t x_end;
    yaddr_t y_end;
  } rect_t;

  // v*30 as v*16 + v*8 + v*4 + v*2; 7*30 = 210 still fits in 8 bits
  function automatic xaddr_t mul30(input logic [2:0] v);
    xaddr_t w;
    w = {5'd0, v};
    return (w << 4) + (w << 3) + (w << 2) + (w << 1);
  endfunction

endpackage

// File: rtl/redraw_scheduler_if.sv
// Pixel bus between the redraw scheduler and the LT24 writer.
// Combinational wiring only.
// pixelWrite/pixelReady: a pixel moves on any cycle where both are high.
interface redraw_scheduler_if;
  import chess_display_pkg::*;

  xaddr_t     xAddr;
  yaddr_t     yAddr;
  logic       pixelWrite;
  logic       pixelReady;
  logic [1:0] regionId;
  logic [5:0] activeSquare;
  logic       regionDone;

  modport master (
    output xAddr, yAddr, pixelWrite, regionId, activeSquare, regionDone,
    input  pixelReady
  );

  modport slave (
    input  xAddr, yAddr, pixelWrite, regionId, activeSquare, regionDone,
    output pixelReady
  );

endinterface

// File: rtl/rr_arbiter64.sv
// Round-robin picker over 64 requests, searching from last+1 upward with wrap.
// Combinational, zero latency.
// No handshake; caller decides when to consume the grant.
module rr_arbiter64 (
  input  logic [63:0] req,
  input  logic [5:0]  last,
  output logic [63:0] grant,
  output logic [5:0]  idx,
  output logic        any
);

  logic [5:0]  start;
  logic [5:0]  offset;
  logic [63:0] rot;

  // Rotate so the search origin sits at bit 0, then take the lowest set bit
  always_comb begin
    start  = last + 6'd1;
    rot    = 64'({req, req} >> start);
    offset = '0;
    for (int i = 63; i >= 0; i--) begin
      if (rot[i]) offset = 6'(i);
    end
    any   = |rot;
    idx   = start + offset;
    grant = any ? (64'd1 << idx) : '0;
  end

endmodule

// File: rtl/redraw_scheduler.sv
// Arbitrates frame/banner/square redraw requests and raster-scans the winner.
// Request pulse at edge k -> ARB at k+1 -> first pixel valid after k+2; 3 overhead cycles per region.
// pixelReady low freezes address and pixelWrite; requests keep accumulating meanwhile.
module redraw_scheduler
  import chess_display_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetApp_n,
  input  logic                      enable,
  input  logic                      frameReq,
  input  logic [1:0]                bannerReq,
  input  logic [63:0]               squareDirty,
  output logic                      busy,
  redraw_scheduler_if.master        pix
);

  state_t      state;

  logic        frame_pend;
  logic [1:0]  banner_pend;
  logic [63:0] square_pend;
  logic [5:0]  last_square;

  // Latched scan bounds; y0 is only needed once, when the scan starts
  xaddr_t      x0_q;
  xaddr_t      x_end_q;
  yaddr_t      y_end_q;

  logic [63:0] sq_grant;
  logic [5:0]  sq_idx;
  logic        sq_any;
  xaddr_t      sq_x0;
  yaddr_t      sq_y0;

  rect_t       win_rect;
  logic [1:0]  win_region;
  logic        win_valid;
  logic        win_frame;
  logic [1:0]  win_banner;
  logic        win_square;

  logic        arb_cycle;
  logic        any_pend;
  logic        last_pixel;

  rr_arbiter64 u_rr (
    .req   (square_pend),
    .last  (last_square),
    .grant (sq_grant),
    .idx   (sq_idx),
    .any   (sq_any)
  );

  assign arb_cycle  = (state == ST_ARB);
  assign any_pend   = frame_pend | (|banner_pend) | (|square_pend);
  assign last_pixel = (pix.xAddr == x_end_q) && (pix.yAddr == y_end_q);

  // idx = row*8 + col: low three bits are the column, high three the row
  assign sq_x0 = mul30(sq_idx[2:0]);
  assign sq_y0 = BOARD_Y0 + {1'b0, mul30(sq_idx[5:3])};

  // Fixed priority: frame, top banner, bottom banner, then round-robin squares
  always_comb begin
    win_valid  = 1'b1;
    win_frame  = 1'b0;
    win_banner = 2'b00;
    win_square = 1'b0;
    win_region = REGION_FRAME;
    win_rect   = '{x0: '0, y0: '0, x_end: X_MAX, y_end: Y_MAX};
    if (frame_pend) begin
      win_frame = 1'b1;
    end else if (banner_pend[0]) begin
      win_banner     = 2'b01;
      win_region     = REGION_BANNER;
      win_rect.y_end = TOP_Y_END;
    end else if (banner_pend[1]) begin
      win_banner  = 2'b10;
      win_region  = REGION_BANNER;
      win_rect.y0 = BOTTOM_Y0;
    end else if (sq_any) begin
      win_square = 1'b1;
      win_region = REGION_SQUARE;
      win_rect   = '{x0: sq_x0, y0: sq_y0,
                     x_end: sq_x0 + SQ_SPAN_X, y_end: sq_y0 + SQ_SPAN_Y};
    end else begin
      win_valid = 1'b0;
    end
  end

  // Pending bits: OR in new pulses after clearing the granted one, so a
  // request landing on its own grant cycle survives and redraws again later
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      frame_pend  <= 1'b0;
      banner_pend <= 2'b00;
      square_pend <= '0;
    end else begin
      frame_pend  <= (frame_pend & ~(arb_cycle & win_frame)) | frameReq;
      banner_pend <= (banner_pend & ~({2{arb_cycle}} & win_banner)) | bannerReq;
      square_pend <= (square_pend & ~({64{arb_cycle & win_square}} & sq_grant))
                     | squareDirty;
    end
  end

  // Main sequencer: arbitrate, latch the rectangle, scan it, pulse done
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      last_square      <= 6'd63;
      x0_q             <= '0;
      x_end_q          <= '0;
      y_end_q          <= '0;
      pix.xAddr        <= '0;
      pix.yAddr        <= '0;
      pix.pixelWrite   <= 1'b0;
      pix.regionId     <= '0;
      pix.activeSquare <= '0;
      pix.regionDone   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && any_pend) begin
            state <= ST_ARB;
            busy  <= 1'b1;
          end
        end
        ST_ARB: begin
          if (win_valid) begin
            x0_q             <= win_rect.x0;
            x_end_q          <= win_rect.x_end;
            y_end_q          <= win_rect.y_end;
            pix.xAddr        <= win_rect.x0;
            pix.yAddr        <= win_rect.y0;
            pix.regionId     <= win_region;
            pix.activeSquare <= win_square ? sq_idx : 6'd0;
            pix.pixelWrite   <= 1'b1;
            if (win_square) last_square <= sq_idx;
            state <= ST_SCAN;
          end else begin
            // Unreachable while pending bits only clear here; recover quietly
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (pix.pixelReady) begin
            if (last_pixel) begin
              pix.pixelWrite <= 1'b0;
              pix.regionDone <= 1'b1;
              state          <= ST_DONE;
            end else if (pix.xAddr == x_end_q) begin
              pix.xAddr <= x0_q;
              pix.yAddr <= pix.yAddr + 9'd1;
            end else begin
              pix.xAddr <= pix.xAddr + 8'd1;
            end
          end
        end
        ST_DONE: begin
          pix.regionDone <= 1'b0;
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/redraw_scheduler.md
Name: redraw_scheduler

Overview:
- Sequences the LT24 pixel interface so that only changed regions of the chess screen are redrawn, instead of streaming the whole 240x320 frame continuously.
- Accepts three request sources: full-frame refresh, top/bottom banner refresh (clock digits), and per-square dirty flags from the layout matrix change detector.
- Arbitrates between them and raster-scans the granted rectangle, driving xAddr/yAddr/pixelWrite.
- Pixel colour lookup stays downstream; it keys off xAddr, yAddr and regionId.

Parameters:
- LCD_WIDTH, 240, display width in pixels
- LCD_HEIGHT, 320, display height in pixels
- BANNER_HEIGHT, 40, height of the top banner and of the bottom banner
- SQUARE_SIZE, 30, chess square edge in pixels; board origin is x=0, y=BANNER_HEIGHT

Ports:
- clock  in  1  system clock
- resetApp_n  in  1  asynchronous active-low reset
- enable  in  1  when low, no new grant is issued; a scan already in progress completes
- frameReq  in  1  single-cycle pulse: redraw the full frame
- bannerReq  in  2  pulse per bit: [0] top banner, [1] bottom banner
- squareDirty  in  64  pulse per bit: square idx = row*8+col needs redraw
- pixelReady  in  1  LT24 accepts the current pixel
- xAddr  out  8  current pixel x
- yAddr  out  9  current pixel y
- pixelWrite  out  1  pixel valid
- regionId  out  2  0 frame, 1 banner, 2 square
- activeSquare  out  6  square being drawn; valid when regionId=2
- busy  out  1  high from ARB through DONE
- regionDone  out  1  one-cycle pulse when the last pixel of a region is accepted

Behaviour:
- Reset values: all outputs 0; pending registers cleared; lastSquare=63; state IDLE.
- Pending registers: framePend, bannerPend[1:0], squarePend[63:0].
  - Each is set by its request pulse (OR-accumulate) and cleared on the ARB cycle that grants it.
  - If a set and a clear hit the same bit in the same cycle, set wins, so the region redraws again later.
- States:
  - IDLE: if enable and any pending bit is set, go to ARB.
  - ARB (1 cycle): select a winner by priority: framePend > bannerPend[0] > bannerPend[1] > squares.
    - Squares use round-robin starting at (lastSquare+1) mod 64 and wrap to 0.
    - Latch the rectangle x0,y0,xEnd,yEnd and regionId; clear the winner's pending bit; update lastSquare if a square won.
  - SCAN: pixelWrite=1, address = current x,y.
  - DONE (1 cycle): regionDone=1, pixelWrite=0, then return to IDLE.
- Rectangles:
  - Frame: (0,0) to (239,319).
  - Top banner: (0,0) to (239,39).
  - Bottom banner: (0,280) to (239,319).
  - Square: x0=col*30, y0=40+row*30, xEnd=x0+29, yEnd=y0+29.
- Handshake: a pixel transfers on any cycle with pixelWrite=1 and pixelReady=1.
  - On transfer: if x==xEnd, then x<=x0 and y<=y+1; otherwise x<=x+1.
  - On a transfer at (xEnd,yEnd), go to DONE.
  - With pixelReady low, address and pixelWrite hold.
- Latency: a request pulse registered at edge k gives IDLE->ARB at edge k+1 and ARB->SCAN at edge k+2. pixelWrite is high with (x0,y0) after edge k+2. With pixelReady held high, a square completes 900 cycles later.
- Idle-to-idle overhead per region: 3 cycles (IDLE, ARB, DONE).
- A region in SCAN is never pre-empted. A frameReq arriving mid-scan is serviced next. Square requests arriving mid-scan accumulate.
- Deasserting enable mid-scan: the scan finishes, then the block stays in IDLE with pending bits retained.
- Asserting resetApp_n low mid-scan: immediate return to reset values; all pending requests are discarded.
- Arithmetic: col/row are the 3-bit fields of idx. Multiply by 30 using shift-add; no divider.

Decomposition:
- Shared package chess_display_pkg holds:
  - LCD/banner/square geometry constants
  - regionId encodings (REGION_FRAME, REGION_BANNER, REGION_SQUARE)
  - state encoding
- Sub-module rr_arbiter64: 64-bit request vector plus last-grant index in, one-hot grant and 6-bit index out, combinational. It is reusable for a later move-highlight scheduler.

Test Plan:
- Reset release, then frameReq pulse with pixelReady=1 -> pixelWrite rises 2 cycles later at (0,0). There are exactly 76800 transfers ending at (239,319), then a single regionDone and busy=0.
- squareDirty bit 9 (row1,col1) -> rectangle x 30..59, y 70..99. There are 900 transfers; activeSquare=9; regionId=2.
- squareDirty bits 0, 5 and 63 in the same cycle together with bannerReq=2'b10 -> service order: bottom banner (y 280..319), then squares 0, 5, 63.
  - A second squareDirty bit 5 pulse issued during square 5's scan causes square 5 to redraw once more afterwards.
- pixelReady toggled randomly during a square scan -> address advances only on ready cycles; no pixel is skipped or duplicated; the transfer count is still 900.
- enable=0 during a banner scan with squareDirty bit 3 pending -> the banner completes and the block stays IDLE. Setting enable=1 -> square 3 is served.
- resetApp_n asserted low mid-frame-scan -> outputs go to 0 immediately. After release the block stays idle with no pending work.
